data_mem_bridge: RTL

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/data_mem_bridge.sv | 120 ++++++++++++
 1 files changed

// File: rtl/data_mem_bridge.sv
// Memory-stage to bus bridge: captures one load/store, runs a valid/ready
// request, waits for a single response, then releases the pipeline.
module data_mem_bridge #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemEn,
    input  logic              MemWriteEn,
    input  logic [XLEN/8-1:0] MemWriteByteEn,
    input  logic [XLEN-1:0]   MemAdr,
    input  logic [XLEN-1:0]   MemWriteData,
    output logic [XLEN-1:0]   MemReadData,
    output logic              MemStall,
    output logic              MemFault,
    output logic              BusReqValid,
    input  logic              BusReqReady,
    output logic              BusWrite,
    output logic [XLEN-1:0]   BusAdr,
    output logic [XLEN-1:0]   BusWdata,
    output logic [XLEN/8-1:0] BusByteEn,
    input  logic              BusRspValid,
    input  logic [XLEN-1:0]   BusRspData,
    input  logic              BusRspErr
);

    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);
    localparam logic [XLEN-1:0] ADR_MASK = {{(XLEN-OFS){1'b1}}, {OFS{1'b0}}};

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    typedef struct packed {
        logic            write;
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] wdata;
        logic [NB-1:0]   byte_en;
    } bus_req_t;

    state_t          state_q, state_d;
    bus_req_t        req_q, req_d;
    logic            capture, rsp_take;
    logic [NB-1:0]   byte_en_d;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;

    // Loads always fetch the full word; stores use the requested lanes.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign byte_en_d[i] = ~MemWriteEn | MemWriteByteEn[i];
    end

    always_comb begin
        req_d.write   = MemWriteEn;
        req_d.adr     = MemAdr & ADR_MASK;
        req_d.wdata   = MemWriteData;
        req_d.byte_en = byte_en_d;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        rsp_take    = 1'b0;
        BusReqValid = 1'b0;
        MemStall    = 1'b0;
        MemFault    = 1'b0;
        case (state_q)
            IDLE: begin
                MemStall = MemEn;
                if (MemEn) begin
                    capture = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                BusReqValid = 1'b1;
                MemStall    = 1'b1;
                if (BusReqReady) state_d = RSP;
            end
            RSP: begin
                MemStall = 1'b1;
                if (BusRspValid) begin
                    rsp_take = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // MemEn here still belongs to the finishing instruction.
                MemFault = fault_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (capture) req_q <= req_d;
            if (rsp_take) begin
                rdata_q <= BusRspErr ? '0 : BusRspData;
                fault_q <= BusRspErr;
            end
        end
    end

    assign BusWrite    = req_q.write;
    assign BusAdr      = req_q.adr;
    assign BusWdata    = req_q.wdata;
    assign BusByteEn   = req_q.byte_en;
    assign MemReadData = rdata_q;

endmodule
